pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use and branch-operand hazards (branches resolve in ID).
//  Issues stalls, ID/EX bubbles and IF/ID flushes; freezes the pipe on data-memory wait.
//  Keeps a saturating stall counter and a sticky memory-timeout flag.
// PARAMETERS
//  CNT_W     16   width of stall_cnt_o (saturates at all-ones)
//  TIMEOUT   255  max consecutive MEMWAIT cycles before err_o sets (1..2^TO_W-1)
//  TO_W      8    width of MEMWAIT cycle counter
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_i           in   1      async reset, active-low
//  start_i         in   1      pipeline enable (same signal fed to pipeline registers)
//  id_rs1_i        in   5      rs1 address of instruction in ID
//  id_rs2_i        in   5      rs2 address of instruction in ID
//  id_uses_rs2_i   in   1      ID instruction reads rs2 (R-type, store, branch)
//  id_branch_i     in   1      ID instruction is a branch
//  branch_taken_i  in   1      branch in ID resolved taken
//  ex_regwrite_i   in   1      RegWrite of ID/EX stage
//  ex_memread_i    in   1      MemRead of ID/EX stage
//  ex_rd_i         in   5      RDaddr of ID/EX stage
//  mem_memread_i   in   1      MemRead of EX/MEM stage
//  mem_rd_i        in   5      RDaddr of EX/MEM stage
//  dmem_stall_i    in   1      data memory busy (level); pipe must hold
//  pc_write_o      out  1      PC register enable
//  if_id_write_o   out  1      IF/ID enable
//  if_id_flush_o   out  1      IF/ID load NOP
//  id_ex_bubble_o  out  1      ID/EX load zero controls (bubble)
//  pipe_hold_o     out  1      hold ID/EX, EX/MEM, MEM/WB contents
//  stall_cnt_o     out  CNT_W  cycles with pc_write_o==0 while state RUN/MEMWAIT
//  err_o           out  1      sticky: MEMWAIT lasted > TIMEOUT cycles
//  state_o         out  2      current FSM state
// BEHAVIOUR
//  Reset (rst_i==0, async): state=IDLE, stall_cnt_o=0, err_o=0, wait counter=0.
//  States: IDLE=0, RUN=1, MEMWAIT=2. Registered; outputs combinational from state+inputs.
//  IDLE: pc_write_o=0, if_id_write_o=0, if_id_flush_o=0, id_ex_bubble_o=1, pipe_hold_o=0.
//    IDLE->RUN when start_i==1.
//  Any state -> IDLE next edge when start_i==0 (counter/err keep value).
//  RUN->MEMWAIT when dmem_stall_i==1; MEMWAIT->RUN when dmem_stall_i==0.
//  Hazard terms (rd==0 never matches):
//    hz_ex  = ex_regwrite_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | id_uses_rs2_i & ex_rd_i==id_rs2_i)
//    hz_mem = mem_memread_i & mem_rd_i!=0 & (same compare with mem_rd_i)
//    stall  = ex_memread_i&hz_ex | id_branch_i&hz_ex | id_branch_i&hz_mem
//    (load->branch thus costs 2 cycles, ALU->branch 1, load->use 1)
//  Priority per cycle: dmem_stall_i > stall > branch_taken_i.
//  MEMWAIT, or RUN with dmem_stall_i==1 (same cycle, combinational): pc_write_o=0,
//    if_id_write_o=0, pipe_hold_o=1, id_ex_bubble_o=0, if_id_flush_o=0.
//  RUN, stall: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, flush=0, hold=0.
//    branch_taken_i ignored while stall (branch re-evaluated after operands ready).
//  RUN, no stall, branch_taken_i: all writes 1, if_id_flush_o=1, bubble=0.
//  RUN, otherwise: pc_write_o=if_id_write_o=1, others 0.
//  stall_cnt_o: +1 each edge with state!=IDLE and pc_write_o==0; holds at 2^CNT_W-1.
//  Wait counter: +1 per edge in MEMWAIT (saturating), cleared on leaving MEMWAIT;
//    err_o sets when counter reaches TIMEOUT while still in MEMWAIT; cleared only by reset.
//  Reset mid-MEMWAIT: immediate IDLE, hold/err cleared.
// STRUCTURE
//  Package pipe_ctrl_pkg: state encodings ST_IDLE/ST_RUN/ST_MEMWAIT, REG_ZERO=5'd0.
//  Sub-module hazard_detect (combinational): computes hz_ex, hz_mem, stall.
//  Top: FSM, output decode, stall counter, wait counter/err.
// TESTING
//  Reset, start_i=1 -> state_o 0->1 next edge; IDLE cycles show bubble=1, pc_write=0.
//  lw x5 in EX, add x6,x5,x1 in ID -> exactly 1 cycle pc_write=0, bubble=1; stall_cnt=1.
//  lw x5 then beq x5,x0 -> 2 stall cycles (EX then MEM), then flush=1 if taken.
//  x0 as rd with ex_memread_i=1, rs1=0 -> no stall.
//  dmem_stall_i high 3 cycles with branch_taken_i=1 -> hold=1, flush=0 for 3 cycles, MEMWAIT.
//  TIMEOUT=4, dmem_stall_i stuck -> err_o=1 after 4 MEMWAIT cycles; sticky until rst_i=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and register-match helper for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  // x0 is hardwired zero, so a write to it never creates a dependency
  function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic uses_rs2);
    return (rd != REG_ZERO) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and branch-operand hazard detection for the ID stage
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs2_i,
  input  logic       id_branch_i,
  input  logic       ex_regwrite_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_memread_i,
  input  logic [4:0] mem_rd_i,
  output logic       hz_ex_o,
  output logic       hz_mem_o,
  output logic       stall_o
);
  // branches resolve in ID, so they also wait on ALU results in EX and loads in MEM
  always_comb begin
    hz_ex_o  = ex_regwrite_i & src_match(ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i);
    hz_mem_o = mem_memread_i & src_match(mem_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i);
    stall_o  = (ex_memread_i & hz_ex_o) | (id_branch_i & hz_ex_o) | (id_branch_i & hz_mem_o);
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequences pipeline register enables, stalls, bubbles and flushes
// and tracks stall cycles plus a sticky data-memory timeout flag
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_branch_i,
  input  logic             branch_taken_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_memread_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             dmem_stall_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o,
  output logic [1:0]       state_o
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   wait_q, wait_d, wait_inc;
  logic              err_q, err_d;
  logic              hz_ex, hz_mem, stall;
  logic              idle, run, freeze, adv, stay_wait;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .id_branch_i   (id_branch_i),
    .ex_regwrite_i (ex_regwrite_i),
    .ex_memread_i  (ex_memread_i),
    .ex_rd_i       (ex_rd_i),
    .mem_memread_i (mem_memread_i),
    .mem_rd_i      (mem_rd_i),
    .hz_ex_o       (hz_ex),
    .hz_mem_o      (hz_mem),
    .stall_o       (stall)
  );

  // memory wait outranks hazard stalls, which outrank a taken branch
  always_comb begin
    idle           = state_q == ST_IDLE;
    run            = state_q == ST_RUN;
    freeze         = (state_q == ST_MEMWAIT) | (run & dmem_stall_i);
    adv            = run & ~dmem_stall_i & ~stall;
    pc_write_o     = adv;
    if_id_write_o  = adv;
    if_id_flush_o  = adv & branch_taken_i;
    id_ex_bubble_o = idle | (run & ~dmem_stall_i & stall);
    pipe_hold_o    = freeze;
    state_d        = !start_i ? ST_IDLE :
                     idle ? ST_RUN :
                     dmem_stall_i ? ST_MEMWAIT : ST_RUN;
    stay_wait      = (state_q == ST_MEMWAIT) & (state_d == ST_MEMWAIT);
    wait_inc       = &wait_q ? wait_q : wait_q + 1'b1;
    wait_d         = stay_wait ? wait_inc : '0;
    err_d          = err_q | (stay_wait & (wait_inc >= TO_W'(TIMEOUT)));
    cnt_d          = (!idle && !adv && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt_o = cnt_q;
  assign err_o       = err_q;
  assign state_o     = state_q;
endmodule
